// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: latches a parallel pattern and shifts it out MSB-first,
// repeating it repeat_cnt times (0 = until stop) with an optional idle gap between repetitions.
module seq_pattern_generator #(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  parameter  int GAP     = 0,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   repeat_cnt,
  output logic               dout,
  output logic               dout_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [7:0] GAP_LAST = 8'(GAP > 0 ? GAP - 1 : 0);

  logic [1:0]         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic               cont_q, cont_d;
  logic [7:0]         gap_q, gap_d;
  logic               dout_q, dout_d, vld_q, vld_d, fs_q, fs_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic len_ok, last_rep;

  function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign last_rep = !cont_q && (rep_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    cont_d  = cont_q;
    gap_d   = gap_q;
    dout_d  = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop outranks start; an illegal length only flags err
        if (start && !stop) begin
          if (len_ok) begin
            state_d = S_SEND;
            pat_d   = pattern;
            len_d   = len;
            rep_d   = repeat_cnt;
            cont_d  = (repeat_cnt == '0);
            idx_d   = len - 1'b1;
            dout_d  = pick(pattern, len - 1'b1);
            vld_d   = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d  = idx_q - 1'b1;
          dout_d = pick(pat_q, idx_q - 1'b1);
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else if (last_rep) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (!cont_q) rep_d = rep_q - 1'b1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
            busy_d  = 1'b1;
          end else begin
            idx_d  = len_q - 1'b1;
            dout_d = pick(pat_q, len_q - 1'b1);
            vld_d  = 1'b1;
            fs_d   = 1'b1;
            busy_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (gap_q == '0) begin
          state_d = S_SEND;
          idx_d   = len_q - 1'b1;
          dout_d  = pick(pat_q, len_q - 1'b1);
          vld_d   = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      cont_q  <= 1'b0;
      gap_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      cont_q  <= cont_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = vld_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Bench for seq_pattern_generator: two instances (GAP=0 and GAP=2) share stimulus and are
// compared cycle by cycle against an expected output stream built from the pattern rules.
module tb_seq_pattern_generator;

  typedef logic [5:0] vq_t[$];

  logic        clk, rst, start, stop;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [7:0]  repeat_cnt;
  logic        dout0, vld0, fs0, busy0, done0, err0;
  logic        dout1, vld1, fs1, busy1, done1, err1;
  logic [5:0]  o0, o1;
  int          n_chk, n_err;

  seq_pattern_generator #(.MAX_LEN(16), .CNT_W(8), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt), .dout(dout0), .dout_valid(vld0), .frame_start(fs0),
    .busy(busy0), .done(done0), .err(err0));

  seq_pattern_generator #(.MAX_LEN(16), .CNT_W(8), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt), .dout(dout1), .dout_valid(vld1), .frame_start(fs1),
    .busy(busy1), .done(done1), .err(err1));

  // {dout, dout_valid, frame_start, busy, done, err}
  assign o0 = {dout0, vld0, fs0, busy0, done0, err0};
  assign o1 = {dout1, vld1, fs1, busy1, done1, err1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream from the first cycle after start onward
  task automatic gen(input logic [15:0] pat, input int l, input int rep, input int gap,
                     input int maxc, output vq_t q);
    int r;
    q = {};
    r = 0;
    forever begin
      for (int i = 0; i < l; i++)
        q.push_back({pat[l-1-i], 1'b1, (i == 0), 1'b1, 1'b0, 1'b0});
      r++;
      if (rep != 0 && r == rep) break;
      if (rep == 0 && q.size() >= maxc) break;
      for (int g = 0; g < gap; g++) q.push_back(6'b000100);
    end
    if (rep != 0) q.push_back(6'b000010);
  endtask

  task automatic cut(input int s, inout vq_t q);
    if (s >= 0 && s < q.size() && q[s][2]) begin
      while (q.size() > s + 1) void'(q.pop_back());
      q.push_back(6'b000000);
    end
  endtask

  task automatic run_txn(input logic [15:0] pat, input int l, input int rep,
                         input int stop_at, input bit busy_start);
    vq_t e0, e1;
    int  n;
    gen(pat, l, rep, 0, stop_at + 2, e0);
    gen(pat, l, rep, 2, stop_at + 2, e1);
    cut(stop_at, e0);
    cut(stop_at, e1);
    n = (e0.size() > e1.size()) ? e0.size() : e1.size();
    while (e0.size() < n) e0.push_back(6'b000000);
    while (e1.size() < n) e1.push_back(6'b000000);
    pattern = pat; len = 5'(l); repeat_cnt = 8'(rep); start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("stream_g0", o0, e0[k]);
      chk("stream_g2", o1, e1[k]);
      pattern    = 16'($urandom);
      len        = 5'($urandom);
      repeat_cnt = 8'($urandom);
      stop       = (k == stop_at);
      start      = busy_start && e0[k][2] && e1[k][2] && ($urandom_range(0, 3) == 0);
      step();
      stop  = 1'b0;
      start = 1'b0;
    end
    chk("idle_g0", o0, 6'b000000);
    chk("idle_g2", o1, 6'b000000);
  endtask

  initial begin
    int l, rep, s;
    n_chk = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    pattern = '0; len = '0; repeat_cnt = '0;
    #3;
    chk("reset_g0", o0, 6'b000000);
    chk("reset_g2", o1, 6'b000000);
    step(); step();
    rst = 1'b0;
    step();

    // 1011 once / 110 twice / loopback pattern with start pulses while busy
    run_txn(16'b1011, 4, 1, -1, 0);
    run_txn(16'b110, 3, 2, -1, 0);
    run_txn(16'b10, 2, 0, 6, 0);
    run_txn(16'b10110110, 8, 3, -1, 1);

    // illegal lengths, and start with stop
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? 5'd0 : 5'd17; pattern = 16'hFFFF; repeat_cnt = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      chk("err_g0", o0, 6'b000001);
      chk("err_g2", o1, 6'b000001);
      step();
      chk("err_clr_g0", o0, 6'b000000);
      chk("err_clr_g2", o1, 6'b000000);
    end
    len = 5'd4; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_g0", o0, 6'b000000);
    chk("startstop_g2", o1, 6'b000000);

    // async reset in the middle of a frame
    pattern = 16'b1011; len = 5'd4; repeat_cnt = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_g0", o0, 6'b000000);
    chk("rst_async_g2", o1, 6'b000000);
    step();
    rst = 1'b0;
    step();
    chk("rst_nodone_g0", o0, 6'b000000);
    chk("rst_nodone_g2", o1, 6'b000000);
    run_txn(16'b1011, 4, 1, -1, 0);

    // boundaries: full length, single-bit frames, maximum repeat count
    run_txn(16'hA5C3, 16, 2, -1, 1);
    run_txn(16'b1, 1, 3, -1, 0);
    run_txn(16'b1, 1, 255, -1, 0);

    for (int t = 0; t < 30; t++) begin
      l   = $urandom_range(1, 16);
      rep = $urandom_range(0, 3);
      if (rep == 0)                      s = $urandom_range(0, 40);
      else if ($urandom_range(0, 2) == 0) s = $urandom_range(0, 30);
      else                               s = -1;
      run_txn(16'($urandom), l, rep, s, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
